// File: rtl/qmax_pkg.sv
// Shared widths and the pipeline-entry record for the Q-max read-compare-write front end.
package qmax_pkg;

  localparam int QMAX_ADDR_WIDTH = 6;
  localparam int QMAX_DATA_WIDTH = 32;
  localparam int QMAX_CNT_WIDTH  = 16;

  typedef struct packed {
    logic                              valid;
    logic [QMAX_ADDR_WIDTH-1:0]        state;
    logic signed [QMAX_DATA_WIDTH-1:0] value;
    logic                              upd;
  } qmax_entry_t;

endpackage

// File: rtl/qmax_fwd_sel.sv
// Picks the freshest known max for the state in stage B: newest in-flight result first,
// then the one-cycle-old history entry, and only then the table read data.
module qmax_fwd_sel
  import qmax_pkg::*;
#(
  parameter int ADDR_WIDTH = QMAX_ADDR_WIDTH,
  parameter int DATA_WIDTH = QMAX_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] i_state_b,
  input  logic                  i_c_valid,
  input  logic [ADDR_WIDTH-1:0] i_c_state,
  input  logic [DATA_WIDTH-1:0] i_c_max,
  input  logic                  i_d_valid,
  input  logic [ADDR_WIDTH-1:0] i_d_state,
  input  logic [DATA_WIDTH-1:0] i_d_max,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic [DATA_WIDTH-1:0] o_old
);

  logic w_hit_c;
  logic w_hit_d;

  assign w_hit_c = i_c_valid && (i_c_state == i_state_b);
  assign w_hit_d = i_d_valid && (i_d_state == i_state_b);

  always_comb begin
    o_old = i_tbl_data;
    if (w_hit_c) begin
      o_old = i_c_max;
    end else if (w_hit_d) begin
      o_old = i_d_max;
    end
  end

endmodule

// File: rtl/qmax_updater.sv
// Read-compare-write pipeline for the Q-max table: read at A, compare at B, write/report at C,
// with stage D remembering the last committed entry to cover the read-during-write edge.
module qmax_updater
  import qmax_pkg::*;
#(
  parameter int ADDR_WIDTH = QMAX_ADDR_WIDTH,
  parameter int DATA_WIDTH = QMAX_DATA_WIDTH,
  parameter int CNT_WIDTH  = QMAX_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic                  o_tbl_read_en,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic                  o_tbl_write_en,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
  output logic [DATA_WIDTH-1:0] o_tbl_data,
  output logic                  o_res_valid,
  output logic [ADDR_WIDTH-1:0] o_res_state,
  output logic [DATA_WIDTH-1:0] o_res_qmax,
  output logic                  o_res_updated,
  output logic [CNT_WIDTH-1:0]  o_wr_count
);

  logic                         w_accept;
  logic signed [DATA_WIDTH-1:0] w_old;
  logic                         w_upd;
  logic signed [DATA_WIDTH-1:0] w_new_max;

  logic                         r_b_valid;
  logic [ADDR_WIDTH-1:0]        r_b_state;
  logic signed [DATA_WIDTH-1:0] r_b_q;

  logic                         r_c_valid;
  logic [ADDR_WIDTH-1:0]        r_c_state;
  logic signed [DATA_WIDTH-1:0] r_c_max;
  logic                         r_c_upd;

  logic                         r_d_valid;
  logic [ADDR_WIDTH-1:0]        r_d_state;
  logic signed [DATA_WIDTH-1:0] r_d_max;

  logic [CNT_WIDTH-1:0]         r_wr_count;

  assign o_ready       = ~i_rst;
  assign w_accept      = i_valid & ~i_rst;
  assign o_tbl_read_en = w_accept;
  assign o_tbl_addr_r  = i_rst ? '0 : i_state;

  qmax_fwd_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fwd_sel (
    .i_state_b  (r_b_state),
    .i_c_valid  (r_c_valid),
    .i_c_state  (r_c_state),
    .i_c_max    (r_c_max),
    .i_d_valid  (r_d_valid),
    .i_d_state  (r_d_state),
    .i_d_max    (r_d_max),
    .i_tbl_data (i_tbl_data),
    .o_old      (w_old)
  );

  // Strict signed compare: an equal candidate leaves the table untouched.
  assign w_upd     = r_b_q > w_old;
  assign w_new_max = w_upd ? r_b_q : w_old;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_b_valid  <= 1'b0;
      r_b_state  <= '0;
      r_b_q      <= '0;
      r_c_valid  <= 1'b0;
      r_c_state  <= '0;
      r_c_max    <= '0;
      r_c_upd    <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_state  <= '0;
      r_d_max    <= '0;
      r_wr_count <= '0;
    end else begin
      r_b_valid <= w_accept;
      r_b_state <= i_state;
      r_b_q     <= i_q;

      r_c_valid <= r_b_valid;
      r_c_state <= r_b_state;
      r_c_max   <= w_new_max;
      r_c_upd   <= r_b_valid & w_upd;

      r_d_valid <= r_c_valid;
      r_d_state <= r_c_state;
      r_d_max   <= r_c_max;

      if (o_tbl_write_en && (r_wr_count != {CNT_WIDTH{1'b1}})) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  assign o_tbl_write_en = r_c_valid & r_c_upd;
  assign o_tbl_addr_w   = r_c_state;
  assign o_tbl_data     = r_c_max;
  assign o_res_valid    = r_c_valid;
  assign o_res_state    = r_c_state;
  assign o_res_qmax     = r_c_max;
  assign o_res_updated  = r_c_upd;
  assign o_wr_count     = r_wr_count;

endmodule
